uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter. Successor to the fixed-format transmitter in the UART-with-FIFO datapath.
- Frame format is selected per frame: divisor, data length 5..DATA_W, parity none/odd/even, 1 or 2 stop bits.
- Adds break generation, a busy flag and a frame-done pulse.
- Sits between the TX FIFO read side (valid/ready) and the pad.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uart_tx_cfg.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the configurable UART
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    MAB
  } tx_state_e;

  localparam int MIN_DIV = 2;
  localparam int MIN_LEN = 5;

  // The reserved encoding 2'b11 behaves like "no parity".
  function automatic logic parity_enabled(input logic [1:0] sel);
    return (sel == PAR_ODD) || (sel == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - restartable baud down-counter with a bit_end pulse every D clocks
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end,
  output logic [DIV_W-1:0] count
);
  import uart_pkg::*;

  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] cnt;

  // Divisors below the minimum are clamped so every bit lasts at least two clocks.
  assign eff_div = (div < MIN_D) ? MIN_D : div;
  assign bit_end = (cnt == '0);
  assign count   = cnt;

  // Counts D-1 down to 0; a restart or reaching 0 reloads, so bit_end repeats every D clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= eff_div - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter with break generation
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data,
  input  logic                        valid,
  output logic                        ready,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [$clog2(DATA_W+1)-1:0] cfg_len,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        break_req,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done
);
  import uart_pkg::*;

  localparam int LEN_W = $clog2(DATA_W + 1);

  tx_state_e         state;
  logic [DIV_W-1:0]  sh_div;
  logic [LEN_W-1:0]  sh_len;
  logic              sh_par_en;
  logic              sh_par_bit;
  logic              sh_stop2;
  logic [DATA_W-1:0] shift;
  logic [LEN_W-1:0]  bit_idx;
  logic              stop_idx;
  logic              min_done;

  logic [LEN_W-1:0]  acc_len;
  logic [DATA_W-1:0] acc_mask;
  logic              acc_par_bit;

  logic              baud_restart;
  logic [DIV_W-1:0]  baud_div;
  logic              bit_end;
  logic [DIV_W-1:0]  baud_count;

  logic              last_data;
  logic              last_stop;
  logic              break_exit;

  assign ready = (state == IDLE) && !break_req;

  // Clamp the requested length; anything outside MIN_LEN..DATA_W sends a full word.
  always_comb begin
    if ((cfg_len < LEN_W'(MIN_LEN)) || (cfg_len > LEN_W'(DATA_W))) begin
      acc_len = LEN_W'(DATA_W);
    end else begin
      acc_len = cfg_len;
    end
  end

  // Only the active data bits contribute to parity; odd parity inverts the even result.
  always_comb begin
    acc_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      acc_mask[i] = (i < int'(acc_len));
    end
    acc_par_bit = (^(data & acc_mask)) ^ (cfg_parity == PAR_ODD);
  end

  assign last_data  = (bit_idx == (sh_len - LEN_W'(1)));
  assign last_stop  = !sh_stop2 || stop_idx;
  assign break_exit = (state == BREAK) && !break_req && (min_done || bit_end);

  // In IDLE the live divisor seeds the counter (frame or break start); afterwards the shadow copy.
  assign baud_div     = (state == IDLE) ? cfg_div : sh_div;
  assign baud_restart = ((state == IDLE) && (break_req || valid)) || break_exit;

  uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (baud_restart),
    .div     (baud_div),
    .bit_end (bit_end),
    .count   (baud_count)
  );

  // Frame sequencer: all line-facing outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sh_div     <= '0;
      sh_len     <= '0;
      sh_par_en  <= 1'b0;
      sh_par_bit <= 1'b0;
      sh_stop2   <= 1'b0;
      shift      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      min_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (break_req) begin
            state    <= BREAK;
            tx       <= 1'b0;
            busy     <= 1'b1;
            sh_div   <= cfg_div;
            min_done <= 1'b0;
          end else if (valid) begin
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            sh_div     <= cfg_div;
            sh_len     <= acc_len;
            sh_par_en  <= parity_enabled(cfg_parity);
            sh_par_bit <= acc_par_bit;
            sh_stop2   <= cfg_stop2;
            shift      <= data;
            stop_idx   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (last_data) begin
              if (sh_par_en) begin
                state <= PARITY;
                tx    <= sh_par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + LEN_W'(1);
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          // Raise frame_done one clock early so it is high exactly in the final stop cycle.
          if (last_stop && (baud_count == DIV_W'(1))) begin
            frame_done <= 1'b1;
          end
          if (bit_end) begin
            if (last_stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        BREAK: begin
          if (bit_end) begin
            min_done <= 1'b1;
          end
          if (break_exit) begin
            state <= MAB;
            tx    <= 1'b1;
          end
        end
        MAB: begin
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg against a bit-list reference model
module tb_uart_tx_cfg;

  logic        clk;
  logic        reset;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_len;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        break_req;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int pass_cnt;
  int total_cnt;

  logic cap_tx[$];
  logic cap_fd[$];
  logic cap_busy[$];
  logic cap_ready[$];
  logic exp_tx[$];
  int   exp_n;

  uart_tx_cfg #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .cfg_div    (cfg_div),
    .cfg_len    (cfg_len),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .break_req  (break_req),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reference: list the line levels bit by bit, then stretch each bit to D clocks.
  task automatic build_model(input logic [7:0] d, input int dv, input int ln, input int pr, input bit s2);
    int dd;
    int ll;
    int ones;
    logic bits[$];
    dd   = (dv < 2) ? 2 : dv;
    ll   = (ln < 5 || ln > 8) ? 8 : ln;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < ll; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pr == 1) bits.push_back((ones % 2) == 0);
    if (pr == 2) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    exp_tx.delete();
    foreach (bits[b]) begin
      for (int r = 0; r < dd; r++) exp_tx.push_back(bits[b]);
    end
    exp_n = exp_tx.size();
  endtask

  task automatic clear_cap();
    cap_tx.delete();
    cap_fd.delete();
    cap_busy.delete();
    cap_ready.delete();
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_tx.push_back(tx);
      cap_fd.push_back(frame_done);
      cap_busy.push_back(busy);
      cap_ready.push_back(ready);
    end
  endtask

  // Presents one frame and returns 1 ns after the accepting edge with valid dropped.
  task automatic start_frame(input logic [7:0] d, input logic [15:0] dv, input logic [3:0] ln,
                             input logic [1:0] pr, input logic s2);
    int waited;
    @(negedge clk);
    data = d; cfg_div = dv; cfg_len = ln; cfg_parity = pr; cfg_stop2 = s2; valid = 1'b1;
    waited = 0;
    while (!ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) begin
      total_cnt++;
      $display("FAIL accept_timeout: ready stayed %b for %0d cycles, required 1", ready, waited);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Counts mismatches of a captured frame starting at cap index off against exp_tx.
  task automatic score_frame(input int off, output int bad_tx, output int bad_fd,
                             output int bad_busy, output int first);
    bad_tx = 0; bad_fd = 0; bad_busy = 0; first = -1;
    for (int k = 0; k < exp_n; k++) begin
      if (cap_tx[off+k] !== exp_tx[k]) begin
        bad_tx++;
        if (first < 0) first = k;
      end
      if (cap_fd[off+k] !== (k == exp_n - 1)) bad_fd++;
      if (cap_busy[off+k] !== 1'b1) bad_busy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; data = '0; valid = 1'b0; cfg_div = 16'd4; cfg_len = 4'd8;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; break_req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b, required 1", tx); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ready); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1 || tx !== 1'b1) $display("FAIL post_reset_idle: ready=%b tx=%b, required 1 1", ready, tx); else pass_cnt++;
  endtask

  task automatic test_8n1();
    int bt, bf, bb, fi, bad_spec;
    logic [9:0] spec_bits;
    spec_bits = 10'b1101001010;
    build_model(8'hA5, 4, 8, 0, 1'b0);
    clear_cap();
    start_frame(8'hA5, 16'd4, 4'd8, 2'b00, 1'b0);
    capture(41);
    score_frame(0, bt, bf, bb, fi);
    bad_spec = 0;
    for (int k = 0; k < 40; k++) if (cap_tx[k] !== spec_bits[k/4]) bad_spec++;
    total_cnt++; if (bt !== 0) $display("FAIL 8n1_wave: %0d cycles differ, first at %0d", bt, fi); else pass_cnt++;
    total_cnt++; if (bad_spec !== 0) $display("FAIL 8n1_bit_list: %0d cycles differ from 0,1,0,1,0,0,1,0,1,1", bad_spec); else pass_cnt++;
    total_cnt++; if (cap_fd[39] !== 1'b1 || bf !== 0) $display("FAIL 8n1_frame_done: at T+40 got %b, %0d misplaced, required 1 and 0", cap_fd[39], bf); else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL 8n1_busy: %0d frame cycles with busy low, required 0", bb); else pass_cnt++;
    total_cnt++; if (cap_ready[40] !== 1'b1 || cap_busy[40] !== 1'b0) $display("FAIL 8n1_ready_after: ready=%b busy=%b at T+41, required 1 0", cap_ready[40], cap_busy[40]); else pass_cnt++;
  endtask

  task automatic test_7e1();
    int bt, bf, bb, fi;
    build_model(8'h83, 3, 7, 2, 1'b0);
    clear_cap();
    start_frame(8'h83, 16'd3, 4'd7, 2'b10, 1'b0);
    capture(31);
    score_frame(0, bt, bf, bb, fi);
    total_cnt++; if (bt !== 0) $display("FAIL 7e1_wave: %0d cycles differ, first at %0d", bt, fi); else pass_cnt++;
    total_cnt++; if (cap_fd[29] !== 1'b1 || bf !== 0) $display("FAIL 7e1_frame_done: at clock 30 got %b, %0d misplaced, required 1 and 0", cap_fd[29], bf); else pass_cnt++;
    total_cnt++; if (cap_ready[30] !== 1'b1) $display("FAIL 7e1_ready_after: got %b, required 1", cap_ready[30]); else pass_cnt++;
  endtask

  task automatic test_5o2();
    int bt, bf, bb, fi;
    logic first_run[$];
    build_model(8'h1F, 2, 5, 1, 1'b1);
    clear_cap();
    start_frame(8'h1F, 16'd2, 4'd5, 2'b01, 1'b1);
    capture(19);
    score_frame(0, bt, bf, bb, fi);
    total_cnt++; if (bt !== 0) $display("FAIL 5o2_wave: %0d cycles differ, first at %0d", bt, fi); else pass_cnt++;
    total_cnt++; if (cap_fd[17] !== 1'b1 || bf !== 0) $display("FAIL 5o2_frame_done: at clock 18 got %b, %0d misplaced, required 1 and 0", cap_fd[17], bf); else pass_cnt++;
    first_run = cap_tx;
    clear_cap();
    start_frame(8'h1F, 16'd0, 4'd5, 2'b01, 1'b1);
    capture(19);
    score_frame(0, bt, bf, bb, fi);
    total_cnt++; if (bt !== 0 || bf !== 0) $display("FAIL 5o2_div0_wave: %0d tx and %0d frame_done cycles differ, first tx at %0d", bt, bf, fi); else pass_cnt++;
    total_cnt++; if (cap_ready[18] !== 1'b1) $display("FAIL 5o2_div0_ready_after: got %b, required 1", cap_ready[18]); else pass_cnt++;
  endtask

  task automatic test_random();
    int bt, bf, bb, fi, dv, ln, pr;
    logic [7:0] d;
    bit s2;
    for (int f = 0; f < 25; f++) begin
      d  = 8'($urandom);
      dv = $urandom_range(0, 6);
      ln = $urandom_range(0, 15);
      pr = $urandom_range(0, 3);
      s2 = 1'($urandom_range(0, 1));
      build_model(d, dv, ln, pr, s2);
      clear_cap();
      start_frame(d, 16'(dv), 4'(ln), 2'(pr), s2);
      capture(exp_n + 1);
      score_frame(0, bt, bf, bb, fi);
      total_cnt++; if (bt !== 0) $display("FAIL rand%0d_wave: d=%h div=%0d len=%0d par=%0d stop2=%0d, %0d cycles differ, first at %0d", f, d, dv, ln, pr, s2, bt, fi); else pass_cnt++;
      total_cnt++; if (bf !== 0 || bb !== 0) $display("FAIL rand%0d_flags: %0d frame_done and %0d busy cycles wrong, required 0", f, bf, bb); else pass_cnt++;
      total_cnt++; if (cap_ready[exp_n] !== 1'b1) $display("FAIL rand%0d_ready_after: got %b, required 1", f, cap_ready[exp_n]); else pass_cnt++;
    end
  endtask

  task automatic test_cfg_change();
    int bt, bf, bb, fi;
    build_model(8'hA5, 4, 8, 0, 1'b0);
    clear_cap();
    start_frame(8'hA5, 16'd4, 4'd8, 2'b00, 1'b0);
    capture(15);
    cfg_len = 4'd5;
    cfg_div = 16'd8;
    capture(26);
    score_frame(0, bt, bf, bb, fi);
    total_cnt++; if (bt !== 0 || bf !== 0) $display("FAIL cfg_change_current: %0d tx and %0d frame_done cycles differ, first tx at %0d", bt, bf, fi); else pass_cnt++;
    build_model(8'h3C, 8, 5, 0, 1'b0);
    clear_cap();
    start_frame(8'h3C, cfg_div, cfg_len, 2'b00, 1'b0);
    capture(exp_n + 1);
    score_frame(0, bt, bf, bb, fi);
    total_cnt++; if (bt !== 0 || bf !== 0) $display("FAIL cfg_change_next: %0d tx and %0d frame_done cycles differ, first tx at %0d", bt, bf, fi); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bt, bf, bb, fi, n1, bad_all;
    logic ref_q[$];
    build_model(8'h6B, 3, 8, 2, 1'b0);
    ref_q = exp_tx;
    n1 = exp_n;
    ref_q.push_back(1'b1);
    build_model(8'hD2, 3, 8, 2, 1'b0);
    foreach (exp_tx[k]) ref_q.push_back(exp_tx[k]);
    clear_cap();
    @(negedge clk);
    data = 8'h6B; cfg_div = 16'd3; cfg_len = 4'd8; cfg_parity = 2'b10; cfg_stop2 = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1 data = 8'hD2;
    capture(n1 + 2);
    valid = 1'b0;
    capture(exp_n);
    bad_all = 0;
    foreach (ref_q[k]) if (cap_tx[k] !== ref_q[k]) bad_all++;
    score_frame(n1 + 1, bt, bf, bb, fi);
    total_cnt++; if (bad_all !== 0) $display("FAIL b2b_wave: %0d cycles differ across both frames, required 0", bad_all); else pass_cnt++;
    total_cnt++; if (cap_fd[n1-1] !== 1'b1 || cap_ready[n1] !== 1'b1 || cap_busy[n1] !== 1'b0) $display("FAIL b2b_gap: fd=%b ready=%b busy=%b, required 1 1 0", cap_fd[n1-1], cap_ready[n1], cap_busy[n1]); else pass_cnt++;
    total_cnt++; if (bf !== 0 || cap_ready[n1+1+exp_n] !== 1'b1) $display("FAIL b2b_second_end: %0d frame_done wrong, ready=%b, required 0 and 1", bf, cap_ready[n1+1+exp_n]); else pass_cnt++;
  endtask

  task automatic test_break();
    int bad_tx, bad_rdy, bad_busy, waited;
    @(negedge clk);
    cfg_div = 16'd10; break_req = 1'b1; valid = 1'b0;
    @(posedge clk);
    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (tx !== (k >= 10)) bad_tx++;
      if (ready !== (k >= 20)) bad_rdy++;
      if (busy !== (k < 20)) bad_busy++;
      if (k == 1) break_req = 1'b0;
    end
    total_cnt++; if (bad_tx !== 0) $display("FAIL break_tx: %0d cycles differ from 10 low then 10 high", bad_tx); else pass_cnt++;
    total_cnt++; if (bad_rdy !== 0 || bad_busy !== 0) $display("FAIL break_flags: %0d ready and %0d busy cycles wrong, required 0", bad_rdy, bad_busy); else pass_cnt++;

    @(negedge clk);
    data = 8'h5A; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_div = 16'd10;
    valid = 1'b1; break_req = 1'b1;
    @(posedge clk);
    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (tx !== (k >= 10 && k <= 20)) bad_tx++;
      if (ready !== (k == 20)) bad_rdy++;
      if (busy !== (k != 20)) bad_busy++;
      if (k == 1) break_req = 1'b0;
    end
    valid = 1'b0;
    total_cnt++; if (bad_tx !== 0) $display("FAIL break_valid_tx: %0d cycles differ, start bit required only after MAB", bad_tx); else pass_cnt++;
    total_cnt++; if (bad_rdy !== 0 || bad_busy !== 0) $display("FAIL break_valid_flags: %0d ready and %0d busy cycles wrong, required 0", bad_rdy, bad_busy); else pass_cnt++;
    waited = 0;
    while (busy && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL break_valid_frame_end: busy=%b after %0d cycles, required 0", busy, waited); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bt, bf, bb, fi;
    start_frame(8'hC3, 16'd4, 4'd8, 2'b00, 1'b0);
    repeat (15) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total_cnt++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL reset_mid: tx=%b busy=%b, required 1 0", tx, busy); else pass_cnt++;
    data = 8'h55; cfg_div = 16'd4; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0; valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 valid = 1'b0;
    build_model(8'h55, 4, 8, 0, 1'b0);
    clear_cap();
    capture(exp_n + 1);
    score_frame(0, bt, bf, bb, fi);
    total_cnt++; if (bt !== 0 || bf !== 0) $display("FAIL reset_mid_next_frame: %0d tx and %0d frame_done cycles differ, first tx at %0d", bt, bf, fi); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_8n1();
    test_7e1();
    test_5o2();
    test_random();
    test_cfg_change();
    test_back_to_back();
    test_break();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
